// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with write-to-read bypass and
// a per-register busy scoreboard set at issue and cleared at writeback.
module regfile_scoreboard #(
   parameter int XLEN   = 32,
   parameter int DEPTH  = 32,
   parameter int NREAD  = 2,
   parameter int NWRITE = 1,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [NREAD-1:0]       i_rd_en,
   input  logic [NREAD*AW-1:0]    i_rd_addr,
   output logic [NREAD*XLEN-1:0]  o_rd_data,
   output logic [NREAD-1:0]       o_rd_busy,
   input  logic [NWRITE-1:0]      i_wr_en,
   input  logic [NWRITE*AW-1:0]   i_wr_addr,
   input  logic [NWRITE*XLEN-1:0] i_wr_data,
   input  logic                   i_issue_en,
   input  logic [AW-1:0]          i_issue_addr,
   output logic [DEPTH-1:0]       o_busy_vec
);

   logic [XLEN-1:0]  r_regs [DEPTH];
   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_set;
   logic [DEPTH-1:0] w_clr;
   logic [DEPTH-1:0] w_busy_nxt;

   // Set beats clear: the issuing instruction is the newer producer.
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (i_issue_en)
         w_set[i_issue_addr] = 1'b1;
      for (int w = 0; w < NWRITE; w++)
         if (i_wr_en[w])
            w_clr[i_wr_addr[w*AW +: AW]] = 1'b1;
      w_busy_nxt    = (r_busy & ~w_clr) | w_set;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int r = 0; r < DEPTH; r++)
            r_regs[r] <= '0;
         r_busy <= '0;
      end else begin
         for (int w = 0; w < NWRITE; w++)
            if (i_wr_en[w] && (i_wr_addr[w*AW +: AW] != '0))
               r_regs[i_wr_addr[w*AW +: AW]] <= i_wr_data[w*XLEN +: XLEN];
         r_busy <= w_busy_nxt;
      end
   end

   // Later write ports override earlier ones on an address match.
   always_comb begin
      o_rd_data = '0;
      o_rd_busy = '0;
      for (int p = 0; p < NREAD; p++) begin
         if (i_rd_en[p] && (i_rd_addr[p*AW +: AW] != '0)) begin
            o_rd_data[p*XLEN +: XLEN] = r_regs[i_rd_addr[p*AW +: AW]];
            o_rd_busy[p] = r_busy[i_rd_addr[p*AW +: AW]];
            if (BYPASS != 0) begin
               for (int w = 0; w < NWRITE; w++) begin
                  if (i_wr_en[w] &&
                      (i_wr_addr[w*AW +: AW] == i_rd_addr[p*AW +: AW])) begin
                     o_rd_data[p*XLEN +: XLEN] = i_wr_data[w*XLEN +: XLEN];
                     o_rd_busy[p] = 1'b0;
                  end
               end
            end
         end
      end
   end

   assign o_busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus random check of regfile_scoreboard against an array model,
// with a bypassing and a non-bypassing instance on shared stimulus.
module tb_regfile_scoreboard;

   logic        clk;
   logic        rst;
   logic [1:0]  rd_en;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data, rd_data_nb;
   logic [1:0]  rd_busy, rd_busy_nb;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        issue_en;
   logic [4:0]  issue_addr;
   logic [31:0] busy_vec, busy_vec_nb;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_reg  [32];
   bit          m_busy [32];

   regfile_scoreboard #(.XLEN(32), .DEPTH(32), .NREAD(2), .NWRITE(2), .BYPASS(1)) u_dut (
      .i_clk(clk), .i_reset(rst),
      .i_rd_en(rd_en), .i_rd_addr(rd_addr),
      .o_rd_data(rd_data), .o_rd_busy(rd_busy),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_issue_en(issue_en), .i_issue_addr(issue_addr),
      .o_busy_vec(busy_vec)
   );

   regfile_scoreboard #(.XLEN(32), .DEPTH(32), .NREAD(2), .NWRITE(2), .BYPASS(0)) u_nb (
      .i_clk(clk), .i_reset(rst),
      .i_rd_en(rd_en), .i_rd_addr(rd_addr),
      .o_rd_data(rd_data_nb), .o_rd_busy(rd_busy_nb),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_issue_en(issue_en), .i_issue_addr(issue_addr),
      .o_busy_vec(busy_vec_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Returns {busy, data} a read port should show right now.
   function automatic logic [32:0] ref_read(input int p, input bit byp);
      int a;
      logic [32:0] r;
      a = int'(rd_addr[p*5 +: 5]);
      if (!rd_en[p] || a == 0) return 33'd0;
      r = {m_busy[a], m_reg[a]};
      if (byp)
         for (int w = 0; w < 2; w++)
            if (wr_en[w] && int'(wr_addr[w*5 +: 5]) == a)
               r = {1'b0, wr_data[w*32 +: 32]};
      return r;
   endfunction

   function automatic logic [31:0] ref_busy_vec();
      logic [31:0] v;
      for (int r = 0; r < 32; r++) v[r] = m_busy[r];
      return v;
   endfunction

   task automatic check_model(input string tag);
      logic [32:0] e;
      for (int p = 0; p < 2; p++) begin
         e = ref_read(p, 1'b1);
         chk($sformatf("%s.byp.data%0d", tag, p), rd_data[p*32 +: 32], e[31:0]);
         chk($sformatf("%s.byp.busy%0d", tag, p), rd_busy[p], e[32]);
         e = ref_read(p, 1'b0);
         chk($sformatf("%s.nb.data%0d", tag, p), rd_data_nb[p*32 +: 32], e[31:0]);
         chk($sformatf("%s.nb.busy%0d", tag, p), rd_busy_nb[p], e[32]);
      end
      chk({tag, ".busy_vec"}, busy_vec, ref_busy_vec());
      chk({tag, ".busy_vec_nb"}, busy_vec_nb, ref_busy_vec());
   endtask

   task automatic update_model();
      if (rst) begin
         for (int r = 0; r < 32; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
         end
      end else begin
         for (int w = 0; w < 2; w++) begin
            if (wr_en[w]) begin
               if (wr_addr[w*5 +: 5] != 0) m_reg[wr_addr[w*5 +: 5]] = wr_data[w*32 +: 32];
               m_busy[wr_addr[w*5 +: 5]] = 1'b0;
            end
         end
         if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
      end
   endtask

   task automatic peek(input string tag);
      #1;
      check_model(tag);
   endtask

   task automatic go(input string tag);
      peek(tag);
      @(posedge clk);
      update_model();
      #1;
   endtask

   task automatic idle();
      wr_en = '0;
      issue_en = 1'b0;
   endtask

   task automatic rd(input int a0, input int a1);
      rd_en = 2'b11;
      rd_addr = {5'(a1), 5'(a0)};
   endtask

   task automatic wr(input int port, input int a, input logic [31:0] d);
      wr_en[port] = 1'b1;
      wr_addr[port*5 +: 5] = 5'(a);
      wr_data[port*32 +: 32] = d;
   endtask

   task automatic iss(input int a);
      issue_en = 1'b1;
      issue_addr = 5'(a);
   endtask

   initial begin
      for (int r = 0; r < 32; r++) begin
         m_reg[r]  = 32'hFFFF_FFFF;
         m_busy[r] = 1'b0;
      end
      rst = 1'b1; rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0;
      wr_data = '0; issue_en = 1'b0; issue_addr = '0;
      @(posedge clk); update_model(); #1;
      rd(3, 9);
      go("rst_held");
      rst = 1'b0;

      for (int a = 0; a < 32; a++) begin
         rd(a, 31 - a);
         peek($sformatf("rst_rd%0d", a));
      end

      wr(0, 5, 32'hDEAD_BEEF); rd(1, 5);
      go("wr_x5");
      idle(); peek("rd_x5");
      chk("x5_port1", rd_data[63:32], 64'hDEAD_BEEF);

      wr(0, 0, 32'h1234); rd(0, 0);
      go("wr_x0");
      idle(); peek("rd_x0");
      chk("x0_zero", rd_data[31:0], 64'd0);

      wr(0, 7, 32'hA5A5_A5A5); rd(7, 7);
      peek("byp_x7");
      chk("byp_x7_data", rd_data[31:0], 64'hA5A5_A5A5);
      chk("byp_x7_busy", rd_busy[0], 64'd0);
      chk("nb_x7_old", rd_data_nb[31:0], 64'd0);
      go("byp_x7_edge");
      idle();

      iss(3); go("iss_x3");
      idle(); rd(3, 3);
      go("idle1"); go("idle2"); go("idle3");
      chk("busy3_vec", busy_vec[3], 64'd1);
      chk("busy3_rd", rd_busy, 64'd3);
      wr(0, 3, 32'd7);
      go("wb_x3");
      idle(); peek("after_wb3");
      chk("x3_busy_clr", busy_vec[3], 64'd0);
      chk("x3_data", rd_data[31:0], 64'd7);

      iss(4); wr(0, 4, 32'd9); rd(4, 4);
      go("iss_wb_x4");
      idle(); peek("after_x4");
      chk("x4_busy_set", busy_vec[4], 64'd1);
      chk("x4_data", rd_data_nb[31:0], 64'd9);

      wr(0, 6, 32'h11); wr(1, 6, 32'h22); rd(6, 6);
      go("dual_wr_x6");
      idle(); peek("after_x6");
      chk("x6_hi_wins", rd_data[63:32], 64'h22);

      iss(1); go("iss1");
      iss(2); go("iss2");
      iss(31); go("iss31");
      idle(); rd(1, 31); peek("pre_rst");
      chk("busy_pre_rst", busy_vec & 32'h8000_0006, 64'h8000_0006);
      rst = 1'b1; wr(0, 1, 32'h5555); iss(9);
      go("mid_rst");
      rst = 1'b0; idle(); peek("post_rst");
      chk("post_rst_busy", busy_vec, 64'd0);
      chk("post_rst_x1", rd_data[31:0], 64'd0);

      wr(0, 6, 32'h66); go("wr_x6b");
      idle(); rd(6, 6); rd_en = 2'b00; peek("rd_dis");
      chk("rd_dis_data", rd_data, 64'd0);

      rd(8, 8);
      iss(8); go("b2b_iss");
      idle(); wr(0, 8, 32'h88); peek("b2b_wb");
      chk("b2b_busy1", busy_vec[8], 64'd1);
      go("b2b_wb_edge");
      idle(); peek("b2b_after");
      chk("b2b_busy0", busy_vec[8], 64'd0);

      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         rd_en = 2'($urandom);
         for (int p = 0; p < 2; p++)
            rd_addr[p*5 +: 5] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         for (int w = 0; w < 2; w++) begin
            wr_en[w] = ($urandom_range(0, 9) < 4);
            wr_addr[w*5 +: 5] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wr_data[w*32 +: 32] = $urandom;
         end
         issue_en = $urandom_range(0, 1);
         issue_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         go($sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-port integer register file with write-to-read bypass and a per-register busy scoreboard. It sits between decode/issue and writeback in the rapid core. Issue marks destination registers busy, and writeback clears them. Read ports return operand data plus a busy flag, so the hazard unit can stall without its own tracking state.

## Interface
- XLEN, 32: data width per register.
- DEPTH, 32: register count. Must be a power of two, ≥ 2. AW = $clog2(DEPTH).
- NREAD, 2: number of read ports, 1..4.
- NWRITE, 1: number of write/writeback ports, 1..2.
- BYPASS, 1: 1 forwards same-cycle write data to reads; 0 means reads see only stored state.

- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  reset; synchronous, active-high.
- i_rd_en  in  NREAD  per-port read enable.
- i_rd_addr  in  NREAD*AW  read addresses; port p uses bits [p*AW +: AW].
- o_rd_data  out  NREAD*XLEN  read data; port p uses bits [p*XLEN +: XLEN].
- o_rd_busy  out  NREAD  addressed register has a pending write.
- i_wr_en  in  NWRITE  per-port write enable.
- i_wr_addr  in  NWRITE*AW  write addresses.
- i_wr_data  in  NWRITE*XLEN  write data.
- i_issue_en  in  1  mark i_issue_addr busy.
- i_issue_addr  in  AW  destination register of the issuing instruction.
- o_busy_vec  out  DEPTH  current busy bits; bit 0 is always 0.

## Operation
- Storage: DEPTH×XLEN flops, plus a DEPTH-bit busy vector.
- Register 0 is hardwired:
  - Reads of address 0 return 0.
  - Writes to address 0 are ignored.
  - Issue to address 0 is ignored, so register 0 is never busy.
- Write: on each edge with i_wr_en[w]=1 and a nonzero address, reg[addr] ← data.
  - Two write ports to the same address in one cycle: the higher index wins.
- Read port p, combinational:
  - i_rd_en[p]=0: data = 0, busy = 0. Never Z.
  - Otherwise, with BYPASS=1 and some enabled write port matching a nonzero address: data = that write data (higher index wins), busy = 0.
  - Otherwise: data = reg[addr], busy = busy[addr].
- Scoreboard, per register r ≠ 0, evaluated each edge:
  - set = i_issue_en && i_issue_addr==r.
  - clr = any i_wr_en[w] && i_wr_addr[w]==r.
  - Next busy = set ? 1 : (clr ? 0 : busy[r]). Set wins over clear, because the issuing instruction is the newer producer.
  - A write to a non-busy register is legal: data is written and busy stays 0.
- Reset, synchronous: on the edge with i_reset=1, all registers ← 0 and all busy ← 0. Writes and issues in that cycle are discarded.

## Timing
- Read latency: 0 cycles, combinational from address and enable.
- Stored-path write latency: 1 cycle; the new value is visible from registers after the edge.
- Bypass path: 0 cycles when BYPASS=1. With BYPASS=0, a same-cycle read returns the old value.
- Busy set by issue: visible in o_busy_vec and o_rd_busy the cycle after the issue edge.
- Busy clear by writeback: visible after the edge. With BYPASS=1, o_rd_busy already reads 0 in the writeback cycle.
- Reset values while i_reset is held, and after release, until written:
  - o_rd_data = 0 for every address.
  - o_rd_busy = 0.
  - o_busy_vec = 0.
- Reset asserted mid-operation, with pending busy bits and concurrent writes: everything clears on that edge. Nothing survives.
- Back-to-back issue then writeback to the same register on consecutive cycles: busy is 1 for exactly one cycle.

## Test plan
- Reset, then read all 32 addresses on both ports -> every o_rd_data = 0 and o_busy_vec = 0.
- Write x5 = 0xDEADBEEF; next cycle read x5 on port 1 -> 0xDEADBEEF. Write x0 = 0x1234, then read x0 -> 0.
- BYPASS=1: write x7 = 0xA5A5A5A5 and read x7 in the same cycle -> 0xA5A5A5A5 and busy 0. BYPASS=0: same stimulus -> old value 0.
- Issue x3, then three idle cycles -> o_busy_vec[3]=1 and o_rd_busy=1 for reads of x3. Writeback x3 = 7 -> busy 0 the next cycle, data reads 7.
- Same cycle: issue x4 and writeback x4 = 9 -> after the edge, busy[4]=1 and reg x4 = 9. NWRITE=2, both ports write x6 (0x11 on port 0, 0x22 on port 1) -> x6 = 0x22.
- Set busy on x1, x2, x31; assert i_reset together with a write of x1 -> next cycle all busy = 0 and x1 reads 0. Disabled read port -> o_rd_data = 0, never Z.
